// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequenced ALU stage:
//   - default datapath and shift-amount widths
//   - opcode encodings (OP_ADD .. OP_SRA); 4'b1001..4'b1111 are undefined
//   - FSM state encoding used by alu_seq_unit
//   - small opcode classification helpers
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_SHAMT_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Opcodes above OP_SRA are undefined.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SRA;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_logic16.sv
// -----------------------------------------------------------------------------
// alu_logic16
// Combinational single-cycle part of the ALU: ADD, SUB, AND, OR, XOR, NOT and
// the signed-overflow flag for ADD/SUB. Shifts and undefined opcodes give
// y = 0, ovf = 0 here; the sequencer handles them.
// Ports:
//   op  - opcode (alu_pkg encodings)
//   a,b - operands
//   y   - result, modulo 2^WIDTH
//   ovf - signed overflow, ADD/SUB only
// -----------------------------------------------------------------------------
module alu_logic16
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;
  logic [WIDTH-1:0] not_y;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  bitwise_and #(.WIDTH(WIDTH)) u_and (.a(a), .b(b), .y(and_y));
  bitwise_or  #(.WIDTH(WIDTH)) u_or  (.a(a), .b(b), .y(or_y));
  bitwise_xor #(.WIDTH(WIDTH)) u_xor (.a(a), .b(b), .y(xor_y));
  bitwise_not #(.WIDTH(WIDTH)) u_not (.a(a), .y(not_y));

  // Carry-out is dropped: both results wrap modulo 2^WIDTH.
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    // NOTE: y and ovf are defaulted before the case so every path assigns
    // them and no latch is inferred.
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = sum;
        // Same-sign operands producing an opposite-sign sum.
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y   = diff;
        // Opposite-sign operands where the difference flips sign from a.
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y = and_y;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      OP_NOT:  y = not_y;
      default: ;
    endcase
  end

endmodule

// File: rtl/bitwise_and.sv
// -----------------------------------------------------------------------------
// bitwise_and
// Gate-level bitwise AND unit shared across the datapath.
// Ports: a, b - operands; y - a & b.
// -----------------------------------------------------------------------------
module bitwise_and #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

// File: rtl/bitwise_not.sv
// -----------------------------------------------------------------------------
// bitwise_not
// Gate-level bitwise inverter unit shared across the datapath.
// Ports: a - operand; y - ~a.
// -----------------------------------------------------------------------------
module bitwise_not #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = ~a;
endmodule

// File: rtl/bitwise_or.sv
// -----------------------------------------------------------------------------
// bitwise_or
// Gate-level bitwise OR unit shared across the datapath.
// Ports: a, b - operands; y - a | b.
// -----------------------------------------------------------------------------
module bitwise_or #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a | b;
endmodule

// File: rtl/bitwise_xor.sv
// -----------------------------------------------------------------------------
// bitwise_xor
// Gate-level bitwise XOR unit shared across the datapath.
// Ports: a, b - operands; y - a ^ b.
// -----------------------------------------------------------------------------
module bitwise_xor #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
// Sequenced ALU stage. Accepts opcode/A/B over a valid/ready handshake,
// computes the result (logic/arith ops in one cycle, shifts one bit per
// cycle), and holds the registered result and flags until the writeback stage
// takes them.
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   in_valid / in_ready  - input handshake; in_ready only in IDLE with rst low
//   opcode, A, B         - operation and operands; B[SHAMT_W-1:0] = shift amount
//   out_valid/out_ready  - output handshake; out_valid only in DONE
//   result               - registered result
//   zero, negative       - result == 0, result MSB
//   overflow             - signed overflow of ADD/SUB
//   illegal              - opcode was undefined (result forced to 0)
// -----------------------------------------------------------------------------
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   work_q,      work_d;
  logic [SHAMT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]         kind_q,      kind_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic               zero_q,      zero_d;
  logic               neg_q,       neg_d;
  logic               ovf_q,       ovf_d;
  logic               ill_q,       ill_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   logic_y;
  logic               logic_ovf;
  logic [WIDTH-1:0]   work_step;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;

  // Final-result bundle: any branch that completes an operation fills these
  // and the flags are derived from commit_res in one place.
  logic               commit;
  logic [WIDTH-1:0]   commit_res;
  logic               commit_ovf;
  logic               commit_ill;

  alu_logic16 #(.WIDTH(WIDTH)) u_logic (
    .op  (opcode),
    .a   (A),
    .b   (B),
    .y   (logic_y),
    .ovf (logic_ovf)
  );

  // in_ready is a function of state and rst only, never of in_valid.
  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign shamt    = B[SHAMT_W-1:0];

  // One-bit step of the working register for the captured shift kind.
  always_comb begin : shift_step
    case (kind_q)
      OP_SLL:  work_step = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  work_step = {1'b0, work_q[WIDTH-1:1]};
      default: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin : next_state
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    commit      = 1'b0;
    commit_res  = '0;
    commit_ovf  = 1'b0;
    commit_ill  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_legal(opcode)) begin
            commit     = 1'b1;
            commit_ill = 1'b1;
          end else if (is_shift(opcode)) begin
            if (shamt == '0) begin
              // Shift by zero is a pass-through with single-cycle latency.
              commit     = 1'b1;
              commit_res = A;
            end else begin
              state_d = S_SHIFT;
              work_d  = A;
              cnt_d   = shamt;
              kind_d  = opcode;
            end
          end else begin
            commit     = 1'b1;
            commit_res = logic_y;
            commit_ovf = logic_ovf;
          end
        end
      end

      S_SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - SHAMT_W'(1);
        // cnt_q == 1 means this step is the last one.
        if (cnt_q == SHAMT_W'(1)) begin
          commit     = 1'b1;
          commit_res = work_step;
        end
      end

      S_DONE: begin
        // Returning to IDLE here (not accepting in the same cycle) creates
        // the one-cycle bubble between back-to-back operations.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      state_d     = S_DONE;
      out_valid_d = 1'b1;
      result_d    = commit_res;
      zero_d      = (commit_res == '0);
      neg_d       = commit_res[WIDTH-1];
      ovf_d       = commit_ovf;
      ill_d       = commit_ill;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      kind_q      <= OP_ADD;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule
